jedro_1_ifu: RTL and testbench

Instruction fetch unit for the jedro_1 core, directly upstream of the decoder. It drives the instruction ROM read port and buffers fetched words in a small prefetch FIFO. It hands instruction/PC pairs to the decoder over a valid/ready handshake. It also handles jump redirects and flags instruction-address-misaligned jump targets.

---
 rtl/jedro_1_ifu_if.sv | 27 ++
 rtl/jedro_1_ifu.sv | 123 ++++++++++++
 tb/tb_jedro_1_ifu.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jedro_1_ifu_if.sv
// Signal bundle between the jedro_1 fetch unit, the instruction ROM and the decoder.
interface jedro_1_ifu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  jmp_i;
  logic [ADDR_WIDTH-1:0] jmp_addr_i;
  logic                  exc_o;
  logic [ADDR_WIDTH-1:0] exc_tval_o;

  modport master (
    output mem_en_o, mem_addr_o, instr_o, addr_o, valid_o, exc_o, exc_tval_o,
    input  mem_rdata_i, ready_i, jmp_i, jmp_addr_i
  );

  modport slave (
    input  mem_en_o, mem_addr_o, instr_o, addr_o, valid_o, exc_o, exc_tval_o,
    output mem_rdata_i, ready_i, jmp_i, jmp_addr_i
  );
endinterface

// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit: issues ROM reads, buffers words in a prefetch FIFO and
// hands instruction/PC pairs to the decoder; handles jumps and misaligned targets.
module jedro_1_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  jedro_1_ifu_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {FETCH, MISALIGNED} state_t;
  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic                  inflight_reg;
  logic [ADDR_WIDTH-1:0] inflight_pc_reg;
  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [DATA_WIDTH-1:0] last_instr_reg;
  logic [ADDR_WIDTH-1:0] last_addr_reg;
  logic [ADDR_WIDTH-1:0] tval_reg;

  logic jmp_aligned;
  logic head_valid;
  logic issue;
  logic push;
  logic pop;

  assign jmp_aligned = (bus.jmp_addr_i[1:0] == 2'b00);
  assign head_valid  = (count_reg != '0);
  // Credit check counts the in-flight word so a response always has a free slot.
  assign issue = !rst_i && !bus.jmp_i && (state_reg == FETCH) &&
                 ((count_reg + CNT_W'(inflight_reg)) < DEPTH_C);
  assign push  = inflight_reg && !bus.jmp_i;
  assign pop   = head_valid && bus.ready_i && !bus.jmp_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bus.exc_o  = 1'b0;
    case (state_reg)
      FETCH:      bus.exc_o = 1'b0;
      MISALIGNED: bus.exc_o = 1'b1;
      default:    bus.exc_o = 1'b0;
    endcase
    if (bus.jmp_i) begin
      state_next = jmp_aligned ? FETCH : MISALIGNED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_reg          <= BOOT_ADDR;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= BOOT_ADDR;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      last_instr_reg  <= '0;
      last_addr_reg   <= '0;
      tval_reg        <= '0;
    end else begin
      // Remember the visible head so the outputs hold once the FIFO drains.
      if (head_valid) begin
        last_instr_reg <= instr_mem[rd_ptr_reg];
        last_addr_reg  <= addr_mem[rd_ptr_reg];
      end
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= pc_reg;
        pc_reg          <= pc_reg + ADDR_WIDTH'(4);
      end
      if (bus.jmp_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        if (jmp_aligned) begin
          pc_reg <= bus.jmp_addr_i;
        end else begin
          tval_reg <= bus.jmp_addr_i;
        end
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        if (push && !pop) begin
          count_reg <= count_reg + CNT_W'(1);
        end else if (!push && pop) begin
          count_reg <= count_reg - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      instr_mem[wr_ptr_reg] <= bus.mem_rdata_i;
      addr_mem[wr_ptr_reg]  <= inflight_pc_reg;
    end
  end

  assign bus.mem_en_o   = issue;
  assign bus.mem_addr_o = pc_reg;
  assign bus.valid_o    = head_valid;
  assign bus.instr_o    = head_valid ? instr_mem[rd_ptr_reg] : last_instr_reg;
  assign bus.addr_o     = head_valid ? addr_mem[rd_ptr_reg] : last_addr_reg;
  assign bus.exc_tval_o = tval_reg;
endmodule

// File: tb/tb_jedro_1_ifu.sv
// Self-checking bench for jedro_1_ifu: directed scenarios plus a randomized run
// against a credit/stream reference model.
module tb_jedro_1_ifu;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_issue = 0;

  always #5 clk = ~clk;

  jedro_1_ifu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  jedro_1_ifu #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BOOT_ADDR (32'h0000_0000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // ROM model: word k holds k; data is only meaningful the cycle after a request.
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      bus.mem_rdata_i <= bus.mem_addr_o >> 2;
      n_issue <= n_issue + 1;
    end else begin
      bus.mem_rdata_i <= $urandom();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.jmp_i = 1'b0;
    bus.jmp_addr_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.ready_i = 1'b1;
    bus.jmp_i = 1'b0;
    bus.jmp_addr_i = '0;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    n_checks++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got=%b exp=0", bus.mem_en_o); end
    n_checks++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr_o); end
    n_checks++; if (bus.exc_o !== 1'b0) begin n_fail++; $display("FAIL reset_exc got=%b exp=0", bus.exc_o); end
    n_checks++; if (bus.exc_tval_o !== 32'h0) begin n_fail++; $display("FAIL reset_tval got=%h exp=0", bus.exc_tval_o); end
    n_checks++; if (bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", bus.instr_o); end
    n_checks++; if (bus.addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.addr_o); end
  endtask

  task automatic test_boot_stream();
    rst = 1'b0;
    settle();
    n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL boot_first_req got en=%b addr=%h exp en=1 addr=0", bus.mem_en_o, bus.mem_addr_o); end
    tick();
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL boot_latency got valid=%b exp=0", bus.valid_o); end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.addr_o !== 32'(4 * k) || bus.instr_o !== 32'(k)) begin
        n_fail++;
        $display("FAIL boot_stream[%0d] got valid=%b addr=%h instr=%h exp valid=1 addr=%h instr=%h",
                 k, bus.valid_o, bus.addr_o, bus.instr_o, 32'(4 * k), 32'(k));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int base;
    bus.ready_i = 1'b0;
    do_reset();
    settle();
    base = n_issue;
    repeat (10) tick();
    n_checks++; if (n_issue - base !== DEPTH) begin n_fail++; $display("FAIL stall_requests got=%0d exp=%0d", n_issue - base, DEPTH); end
    n_checks++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_mem_en got=%b exp=0", bus.mem_en_o); end
    n_checks++; if (bus.mem_addr_o !== 32'h10) begin n_fail++; $display("FAIL stall_pc got=%h exp=10", bus.mem_addr_o); end
    bus.ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.addr_o !== 32'(4 * k) || bus.instr_o !== 32'(k)) begin
        n_fail++;
        $display("FAIL stall_drain[%0d] got valid=%b addr=%h instr=%h exp valid=1 addr=%h instr=%h",
                 k, bus.valid_o, bus.addr_o, bus.instr_o, 32'(4 * k), 32'(k));
      end
      tick();
    end
  endtask

  task automatic test_jump_flush();
    bus.ready_i = 1'b0;
    do_reset();
    repeat (4) tick();
    bus.jmp_i = 1'b1;
    bus.jmp_addr_i = 32'h40;
    bus.ready_i = 1'b1;
    settle();
    n_checks++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL jump_blocks_issue got=%b exp=0", bus.mem_en_o); end
    tick();
    bus.jmp_i = 1'b0;
    settle();
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL jump_flush_valid got=%b exp=0", bus.valid_o); end
    n_checks++; if (bus.addr_o !== 32'h0) begin n_fail++; $display("FAIL jump_hold_addr got=%h exp=0", bus.addr_o); end
    n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 32'h40) begin n_fail++; $display("FAIL jump_target_req got en=%b addr=%h exp en=1 addr=40", bus.mem_en_o, bus.mem_addr_o); end
    tick();
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL jump_latency got valid=%b exp=0", bus.valid_o); end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.addr_o !== 32'(32'h40 + 4 * k) || bus.instr_o !== 32'(16 + k)) begin
        n_fail++;
        $display("FAIL jump_stream[%0d] got valid=%b addr=%h instr=%h exp addr=%h instr=%h",
                 k, bus.valid_o, bus.addr_o, bus.instr_o, 32'(32'h40 + 4 * k), 32'(16 + k));
      end
      tick();
    end
  endtask

  task automatic test_misaligned();
    bus.jmp_i = 1'b1;
    bus.jmp_addr_i = 32'h102;
    tick();
    bus.jmp_i = 1'b0;
    settle();
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (bus.exc_o !== 1'b1 || bus.exc_tval_o !== 32'h102 || bus.mem_en_o !== 1'b0 || bus.valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_hold[%0d] got exc=%b tval=%h en=%b valid=%b exp exc=1 tval=102 en=0 valid=0",
                 c, bus.exc_o, bus.exc_tval_o, bus.mem_en_o, bus.valid_o);
      end
      tick();
    end
    bus.jmp_i = 1'b1;
    bus.jmp_addr_i = 32'h201;
    tick();
    bus.jmp_i = 1'b0;
    settle();
    n_checks++; if (bus.exc_o !== 1'b1 || bus.exc_tval_o !== 32'h201) begin n_fail++; $display("FAIL misaligned_update got exc=%b tval=%h exp exc=1 tval=201", bus.exc_o, bus.exc_tval_o); end
    bus.jmp_i = 1'b1;
    bus.jmp_addr_i = 32'h80;
    tick();
    bus.jmp_i = 1'b0;
    settle();
    n_checks++; if (bus.exc_o !== 1'b0) begin n_fail++; $display("FAIL misaligned_exit got exc=%b exp=0", bus.exc_o); end
    n_checks++; if (bus.exc_tval_o !== 32'h201) begin n_fail++; $display("FAIL tval_hold got=%h exp=201", bus.exc_tval_o); end
    n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 32'h80) begin n_fail++; $display("FAIL trap_vector_req got en=%b addr=%h exp en=1 addr=80", bus.mem_en_o, bus.mem_addr_o); end
    tick();
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL trap_latency got valid=%b exp=0", bus.valid_o); end
    tick();
    n_checks++; if (bus.valid_o !== 1'b1 || bus.addr_o !== 32'h80 || bus.instr_o !== 32'h20) begin n_fail++; $display("FAIL trap_first got valid=%b addr=%h instr=%h exp valid=1 addr=80 instr=20", bus.valid_o, bus.addr_o, bus.instr_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    bus.ready_i = 1'b1;
    bus.jmp_i = 1'b1;
    bus.jmp_addr_i = 32'hFFFF_FFF8;
    tick();
    bus.jmp_i = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      ea = 32'hFFFF_FFF8 + 32'(4 * k);
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.addr_o !== ea || bus.instr_o !== (ea >> 2)) begin
        n_fail++;
        $display("FAIL wrap[%0d] got valid=%b addr=%h instr=%h exp addr=%h instr=%h",
                 k, bus.valid_o, bus.addr_o, bus.instr_o, ea, ea >> 2);
      end
      tick();
    end
  endtask

  task automatic test_reset_priority();
    bus.ready_i = 1'b0;
    bus.jmp_i = 1'b1;
    bus.jmp_addr_i = 32'h200;
    tick();
    bus.jmp_i = 1'b0;
    repeat (8) tick();
    n_checks++; if (bus.mem_en_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.addr_o !== 32'h200 || bus.instr_o !== 32'h80) begin n_fail++; $display("FAIL prefill got en=%b valid=%b addr=%h instr=%h exp en=0 valid=1 addr=200 instr=80", bus.mem_en_o, bus.valid_o, bus.addr_o, bus.instr_o); end
    rst = 1'b1;
    bus.jmp_i = 1'b1;
    bus.jmp_addr_i = 32'h43;
    tick();
    n_checks++; if (bus.valid_o !== 1'b0 || bus.mem_en_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rstprio_fetch got valid=%b en=%b maddr=%h exp 0 0 0", bus.valid_o, bus.mem_en_o, bus.mem_addr_o); end
    n_checks++; if (bus.exc_o !== 1'b0 || bus.exc_tval_o !== 32'h0) begin n_fail++; $display("FAIL rstprio_exc got exc=%b tval=%h exp 0 0", bus.exc_o, bus.exc_tval_o); end
    n_checks++; if (bus.instr_o !== 32'h0 || bus.addr_o !== 32'h0) begin n_fail++; $display("FAIL rstprio_head got instr=%h addr=%h exp 0 0", bus.instr_o, bus.addr_o); end
    rst = 1'b0;
    bus.jmp_i = 1'b0;
    bus.ready_i = 1'b1;
    settle();
    n_checks++; if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rstprio_refetch got en=%b addr=%h exp en=1 addr=0", bus.mem_en_o, bus.mem_addr_o); end
    tick();
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rstprio_latency got valid=%b exp=0", bus.valid_o); end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.addr_o !== 32'(4 * k) || bus.instr_o !== 32'(k)) begin
        n_fail++;
        $display("FAIL rstprio_stream[%0d] got valid=%b addr=%h instr=%h exp addr=%h instr=%h",
                 k, bus.valid_o, bus.addr_o, bus.instr_o, 32'(4 * k), 32'(k));
      end
      tick();
    end
  endtask

  // Reference model: since the last aligned jump, the decoder must see target,
  // target+4, ...; at most DEPTH words may be requested but not yet accepted.
  task automatic test_random();
    logic [31:0] base, tval_m, frozen, ja, ea, eh;
    int iss, lnd, pops;
    bit in_exc, infl, en_e, val_e, pop_e, r, j;
    bus.ready_i = 1'b1;
    do_reset();
    base = '0; tval_m = '0; frozen = '0;
    iss = 0; lnd = 0; pops = 0;
    in_exc = 1'b0; infl = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 3) != 0);
      j = ($urandom_range(0, 19) == 0);
      ja = $urandom();
      if ($urandom_range(0, 3) == 0) ja[1:0] = 2'($urandom_range(1, 3));
      else ja[1:0] = 2'b00;
      bus.ready_i = r;
      bus.jmp_i = j;
      bus.jmp_addr_i = ja;
      settle();
      en_e  = !in_exc && !j && ((iss - pops) < DEPTH);
      val_e = !in_exc && ((lnd - pops) > 0);
      pop_e = val_e && r && !j;
      ea = in_exc ? frozen : base + 32'(4 * iss);
      n_checks++; if (bus.mem_en_o !== en_e) begin n_fail++; $display("FAIL rand_mem_en[%0d] got=%b exp=%b", c, bus.mem_en_o, en_e); end
      n_checks++; if (bus.mem_addr_o !== ea) begin n_fail++; $display("FAIL rand_pc[%0d] got=%h exp=%h", c, bus.mem_addr_o, ea); end
      n_checks++; if (bus.valid_o !== val_e) begin n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, bus.valid_o, val_e); end
      n_checks++; if (bus.exc_o !== in_exc || bus.exc_tval_o !== tval_m) begin n_fail++; $display("FAIL rand_exc[%0d] got exc=%b tval=%h exp exc=%b tval=%h", c, bus.exc_o, bus.exc_tval_o, in_exc, tval_m); end
      if (val_e) begin
        eh = base + 32'(4 * pops);
        n_checks++;
        if (bus.addr_o !== eh || bus.instr_o !== (eh >> 2)) begin
          n_fail++;
          $display("FAIL rand_head[%0d] got addr=%h instr=%h exp addr=%h instr=%h", c, bus.addr_o, bus.instr_o, eh, eh >> 2);
        end
      end
      if (pop_e) $display("pop addr=%08h instr=%08h", bus.addr_o, bus.instr_o);
      if (j) $display("jump target=%08h", ja);
      tick();
      if (j) begin
        if (ja[1:0] == 2'b00) begin
          base = ja;
          in_exc = 1'b0;
        end else begin
          if (!in_exc) frozen = base + 32'(4 * iss);
          in_exc = 1'b1;
          tval_m = ja;
        end
        iss = 0; lnd = 0; pops = 0; infl = 1'b0;
      end else begin
        lnd  += int'(infl);
        infl  = en_e;
        iss  += int'(en_e);
        pops += int'(pop_e);
      end
    end
    bus.jmp_i = 1'b0;
  endtask

  initial begin
    bus.ready_i = 1'b1;
    bus.jmp_i = 1'b0;
    bus.jmp_addr_i = '0;
    bus.mem_rdata_i = '0;
    test_reset();
    test_boot_stream();
    test_stall();
    test_jump_flush();
    test_misaligned();
    test_wrap();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
